// File: rtl/calc_pkg.sv
// ============================================================================
// Module   : calc_pkg
// Brief    : Shared types and constants for the 4-bit calculator front-end.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package calc_pkg;

    localparam int CALC_WIDTH = 4;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    typedef enum logic [1:0] {
        WAIT_A = 2'd0,
        WAIT_B = 2'd1,
        READY  = 2'd2
    } loader_state_t;

endpackage

`default_nettype wire

// File: rtl/btn_conditioner.sv
// ============================================================================
// Module   : btn_conditioner
// Brief    : Two-flop synchronizer, optional debounce and rising-edge detect
//            for one raw push-button.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_conditioner #(
    parameter bit DEBOUNCE_EN     = 1'b0,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_level,
    output logic o_rise
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;
    logic w_level;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
        end
    end

    generate
        if (DEBOUNCE_EN) begin : g_debounce
            localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

            logic [CNT_W-1:0] r_cnt;
            logic             r_deb;

            // The flip happens on the DEBOUNCE_CYCLES-th consecutive cycle of disagreement.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_cnt <= '0;
                    r_deb <= 1'b0;
                end else if (r_sync2 == r_deb) begin
                    r_cnt <= '0;
                end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    r_cnt <= '0;
                    r_deb <= ~r_deb;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end

            assign w_level = r_deb;
        end else begin : g_no_debounce
            assign w_level = r_sync2;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= w_level;
        end
    end

    assign o_level = w_level;
    assign o_rise  = w_level & ~r_prev;

endmodule

`default_nettype wire

// File: rtl/operand_loader.sv
// ============================================================================
// Module   : operand_loader
// Brief    : Captures two operands on successive load presses, then toggles
//            the mux select. Debounce enabled by OPERAND_LOADER_DEBOUNCE_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module operand_loader
    import calc_pkg::*;
#(
    parameter int WIDTH           = CALC_WIDTH,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw,
    input  logic             btn_load,
    input  logic             btn_clear,
    output logic [WIDTH-1:0] in0,
    output logic [WIDTH-1:0] in1,
    output logic             sel,
    output logic             operands_valid
);

`ifdef OPERAND_LOADER_DEBOUNCE_EN
    localparam bit c_load_debounce = 1'b1;
`else
    localparam bit c_load_debounce = 1'b0;
`endif

    loader_state_t r_state;
    logic          w_load_pulse;
    logic          w_load_level;
    logic          w_clear;

    btn_conditioner #(
        .DEBOUNCE_EN     (c_load_debounce),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_load_cond (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_btn   (btn_load),
        .o_level (w_load_level),
        .o_rise  (w_load_pulse)
    );

    // Clear is level-sensitive, so only the synchronized level is used.
    btn_conditioner #(
        .DEBOUNCE_EN     (1'b0),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_clear_cond (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_btn   (btn_clear),
        .o_level (w_clear),
        .o_rise  ()
    );

    always_ff @(posedge clk) begin
        if (!rst_n || w_clear) begin
            r_state        <= WAIT_A;
            in0            <= '0;
            in1            <= '0;
            sel            <= SEL_A;
            operands_valid <= 1'b0;
        end else if (w_load_pulse) begin
            case (r_state)
                WAIT_A: begin
                    in0     <= sw;
                    r_state <= WAIT_B;
                end
                WAIT_B: begin
                    in1            <= sw;
                    r_state        <= READY;
                    operands_valid <= 1'b1;
                end
                READY: begin
                    sel <= ~sel;
                end
                default: begin
                    r_state        <= WAIT_A;
                    sel            <= SEL_A;
                    operands_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_operand_loader.sv
// ============================================================================
// Module   : tb_operand_loader
// Brief    : Directed self-checking bench for operand_loader; the debounce
//            case runs when OPERAND_LOADER_DEBOUNCE_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_operand_loader;

    localparam int c_width = 4;
    localparam int c_deb   = 4;
`ifdef OPERAND_LOADER_DEBOUNCE_EN
    localparam int c_hold = 10;
    localparam int c_gap  = 10;
`else
    localparam int c_hold = 3;
    localparam int c_gap  = 3;
`endif

    logic               clk = 1'b0;
    logic               rst_n;
    logic [c_width-1:0] sw;
    logic               btn_load;
    logic               btn_clear;
    logic [c_width-1:0] in0;
    logic [c_width-1:0] in1;
    logic               sel;
    logic               operands_valid;

    int n_checks = 0;
    int n_errors = 0;

    operand_loader #(
        .WIDTH           (c_width),
        .DEBOUNCE_CYCLES (c_deb)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .sw             (sw),
        .btn_load       (btn_load),
        .btn_clear      (btn_clear),
        .in0            (in0),
        .in1            (in1),
        .sel            (sel),
        .operands_valid (operands_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press();
        btn_load = 1'b1;
        tick(c_hold);
        btn_load = 1'b0;
        tick(c_gap);
    endtask

    task automatic clear_all();
        btn_clear = 1'b1;
        tick(c_hold);
        btn_clear = 1'b0;
        tick(c_gap);
    endtask

    task automatic check_all(input string tag, input logic [3:0] e0, input logic [3:0] e1,
                             input logic es, input logic ev);
        check({tag, ".in0"}, in0, e0);
        check({tag, ".in1"}, in1, e1);
        check({tag, ".sel"}, sel, es);
        check({tag, ".valid"}, operands_valid, ev);
    endtask

    initial begin
        rst_n     = 1'b0;
        sw        = '0;
        btn_load  = 1'b0;
        btn_clear = 1'b0;

        // Reset values
        tick(3);
        rst_n = 1'b1;
        tick();
        check_all("reset", 4'h0, 4'h0, 1'b0, 1'b0);

`ifndef OPERAND_LOADER_DEBOUNCE_EN
        // Operand A with exact latency: edge k samples the button, in0 updates at k+2
        sw       = 4'b1010;
        btn_load = 1'b1;
        tick();
        check("a_lat_k", in0, 4'h0);
        tick();
        check("a_lat_k1", in0, 4'h0);
        tick();
        check("a_lat_k2", in0, 4'b1010);
        btn_load = 1'b0;
        tick(c_gap);
`else
        sw = 4'b1010;
        press();
        check("a_load", in0, 4'b1010);
`endif
        check("a_valid", operands_valid, 1'b0);

        sw = 4'b0101;
        press();
        check_all("b_load", 4'b1010, 4'b0101, 1'b0, 1'b1);

        // Select toggling in READY
        press();
        check_all("tog1", 4'b1010, 4'b0101, 1'b1, 1'b1);
        press();
        check_all("tog2", 4'b1010, 4'b0101, 1'b0, 1'b1);
        press();
        check_all("tog3", 4'b1010, 4'b0101, 1'b1, 1'b1);

        // Clear wins over a simultaneous load
        clear_all();
        check_all("clr", 4'h0, 4'h0, 1'b0, 1'b0);
        sw = 4'b0011;
        press();
        check("a3_load", in0, 4'b0011);
        btn_clear = 1'b1;
        btn_load  = 1'b1;
        tick(c_hold);
        btn_clear = 1'b0;
        btn_load  = 1'b0;
        tick(c_gap);
        check_all("clr_prio", 4'h0, 4'h0, 1'b0, 1'b0);
        sw = 4'b0110;
        press();
        check_all("after_clr", 4'b0110, 4'h0, 1'b0, 1'b0);

        // Held button yields a single load
        clear_all();
        sw       = 4'b1111;
        btn_load = 1'b1;
        tick(50);
        btn_load = 1'b0;
        tick(c_gap);
        check_all("held", 4'b1111, 4'h0, 1'b0, 1'b0);

`ifdef OPERAND_LOADER_DEBOUNCE_EN
        clear_all();
        sw       = 4'b1001;
        btn_load = 1'b1;
        tick(3);
        btn_load = 1'b0;
        tick(12);
        check("glitch", in0, 4'h0);

        // Edge k is the first tick below; in0 must change exactly at k+6
        btn_load = 1'b1;
        tick(6);
        check("deb_k5", in0, 4'h0);
        tick();
        check("deb_k6", in0, 4'b1001);
        tick(3);
        btn_load = 1'b0;
        tick(12);
        check("deb_release", in1, 4'h0);
`endif

        // Reset mid-entry discards the partial operand
        clear_all();
        sw = 4'b0111;
        press();
        check("mid_a", in0, 4'b0111);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check_all("mid_rst", 4'h0, 4'h0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
